// File: rtl/lock_abs_peak_arb.sv
// lock_abs_peak_arb: round-robin arbiter feeding one shared saturating
// |x| stage, followed by per-channel windowed peak trackers.

// Per-channel window tracker: running max, sample count, published peak.
module lock_abs_peak_upd #(
  parameter int R = 14,
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         upd,
  input  logic [R-2:0] mag,
  input  logic [W-1:0] eff_len,
  output logic [R-2:0] peak,
  output logic         peak_vld
);
  logic [R-2:0] run_max;
  logic [W-1:0] cnt;
  logic [W:0]   cnt_nxt;
  logic [R-2:0] max_nxt;
  logic         closes;

  // Candidate max including the current sample, and window-close test.
  always_comb begin
    cnt_nxt = {1'b0, cnt} + (W+1)'(1);
    max_nxt = (mag > run_max) ? mag : run_max;
    closes  = cnt_nxt >= {1'b0, eff_len};
  end

  // Clear wins over updates; the published peak survives a clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_max  <= '0;
      cnt      <= '0;
      peak     <= '0;
      peak_vld <= 1'b0;
    end else if (clr) begin
      run_max  <= '0;
      cnt      <= '0;
      peak_vld <= 1'b0;
    end else begin
      peak_vld <= 1'b0;
      if (upd) begin
        if (closes) begin
          peak     <= max_nxt;
          peak_vld <= 1'b1;
          run_max  <= '0;
          cnt      <= '0;
        end else begin
          run_max  <= max_nxt;
          cnt      <= cnt_nxt[W-1:0];
        end
      end
    end
  end
endmodule

module lock_abs_peak_arb #(
  parameter int R = 14,
  parameter int N = 4,
  parameter int W = 20
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N-1:0]     ch_val_i,
  input  logic [N*R-1:0]   ch_dat_i,
  output logic [N-1:0]     ch_rdy_o,
  input  logic [W-1:0]     win_len_i,
  input  logic             clr_i,
  output logic [N*(R-1)-1:0] peak_o,
  output logic [N-1:0]     peak_vld_o,
  output logic             busy_o
);
  localparam int CW = $clog2(N);
  localparam int M  = R - 1;

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] ch;
    logic [R-1:0]  dat;
  } stage_a_t;

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] ch;
    logic [M-1:0]  mag;
  } stage_b_t;

  logic [CW-1:0] ptr;
  logic [CW-1:0] gidx;
  logic          gnt_any;
  logic [N-1:0]  grant;
  logic [R-1:0]  acc_dat;
  stage_a_t      sa;
  stage_b_t      sb;
  logic [M-1:0]  mag;
  logic [R-1:0]  neg;
  logic [W-1:0]  eff_len;

  // Round-robin search starting at the pointer, wrapping N-1 -> 0.
  always_comb begin
    int j;
    grant   = '0;
    gidx    = '0;
    gnt_any = 1'b0;
    acc_dat = '0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!gnt_any && ch_val_i[j]) begin
        gnt_any  = 1'b1;
        gidx     = CW'(j);
        grant[j] = 1'b1;
        acc_dat  = ch_dat_i[j*R +: R];
      end
    end
  end

  assign ch_rdy_o = grant;

  // Pointer moves past the granted channel; holds when nothing is valid.
  always_ff @(posedge clk_i) begin
    if (!rstn_i)
      ptr <= '0;
    else if (gnt_any)
      ptr <= (gidx == CW'(N-1)) ? '0 : gidx + CW'(1);
  end

  // Saturating magnitude: the most negative code maps to full scale.
  always_comb begin
    neg = -sa.dat;
    if (!sa.dat[R-1])
      mag = sa.dat[M-1:0];
    else if (sa.dat == {1'b1, {M{1'b0}}})
      mag = '1;
    else
      mag = neg[M-1:0];
  end

  // Two-stage pipeline; a clear drops both stages but still takes this
  // cycle's accept into stage A.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sa <= '0;
      sb <= '0;
    end else begin
      sa.vld <= gnt_any;
      sa.ch  <= gidx;
      sa.dat <= acc_dat;
      sb.vld <= sa.vld & ~clr_i;
      sb.ch  <= sa.ch;
      sb.mag <= mag;
    end
  end

  assign eff_len = (win_len_i == '0) ? W'(1) : win_len_i;
  assign busy_o  = sa.vld | sb.vld;

  for (genvar k = 0; k < N; k++) begin : g_ch
    lock_abs_peak_upd #(.R(R), .W(W)) u_upd (
      .clk      (clk_i),
      .rstn     (rstn_i),
      .clr      (clr_i),
      .upd      (sb.vld && (sb.ch == CW'(k))),
      .mag      (sb.mag),
      .eff_len  (eff_len),
      .peak     (peak_o[k*M +: M]),
      .peak_vld (peak_vld_o[k])
    );
  end
endmodule

// File: tb/tb_lock_abs_peak_arb.sv
// Randomized and directed bench for lock_abs_peak_arb against a
// sample-queue reference model.
module tb_lock_abs_peak_arb;
  localparam int R = 14;
  localparam int N = 4;
  localparam int W = 20;
  localparam int M = R - 1;
  localparam int MAXMAG = (1 << (R-1)) - 1;

  logic             clk = 1'b0;
  logic             rstn_i;
  logic [N-1:0]     ch_val_i;
  logic [N*R-1:0]   ch_dat_i;
  logic [N-1:0]     ch_rdy_o;
  logic [W-1:0]     win_len_i;
  logic             clr_i;
  logic [N*M-1:0]   peak_o;
  logic [N-1:0]     peak_vld_o;
  logic             busy_o;

  always #4 clk = ~clk;

  lock_abs_peak_arb #(.R(R), .N(N), .W(W)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .ch_val_i(ch_val_i), .ch_dat_i(ch_dat_i),
    .ch_rdy_o(ch_rdy_o), .win_len_i(win_len_i), .clr_i(clr_i),
    .peak_o(peak_o), .peak_vld_o(peak_vld_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: accepted samples wait in a queue until their update cycle.
  typedef struct {
    int ch;
    int mag;
    int due;
  } ent_t;
  ent_t q[$];
  int   cyc;
  int   m_ptr;
  int   rm[N];
  int   cn[N];
  int   pk[N];
  logic [N-1:0] exp_vld;
  int   dv[N];

  logic [N-1:0]   obs_rdy;
  logic [N-1:0]   obs_vld;
  logic [N*M-1:0] obs_peak;

  function automatic int absmag(input int x);
    int a;
    a = (x < 0) ? -x : x;
    return (a > MAXMAG) ? MAXMAG : a;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr = 0;
    exp_vld = '0;
    for (int k = 0; k < N; k++) begin
      rm[k] = 0; cn[k] = 0; pk[k] = 0;
    end
  endtask

  // One clock: drive, compare every output against the model, advance model.
  task automatic step(input logic [N-1:0] val, input int win, input bit clr);
    int g, j, eff, mx;
    logic [N-1:0]   e_rdy;
    logic [N*M-1:0] e_pk;
    ent_t e;
    ch_val_i  = val;
    win_len_i = W'(win);
    clr_i     = clr;
    for (int k = 0; k < N; k++) ch_dat_i[k*R +: R] = R'(dv[k]);
    @(negedge clk);
    g = -1;
    for (int i = 0; i < N; i++) begin
      j = (m_ptr + i) % N;
      if (val[j] && g < 0) g = j;
    end
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    for (int k = 0; k < N; k++) e_pk[k*M +: M] = M'(pk[k]);
    obs_rdy = ch_rdy_o; obs_vld = peak_vld_o; obs_peak = peak_o;
    checks++;
    if (ch_rdy_o !== e_rdy) begin
      errors++; $display("FAIL grant cyc=%0d got %b want %b", cyc, ch_rdy_o, e_rdy);
    end
    checks++;
    if (peak_vld_o !== exp_vld) begin
      errors++; $display("FAIL peak_vld cyc=%0d got %b want %b", cyc, peak_vld_o, exp_vld);
    end
    checks++;
    if (peak_o !== e_pk) begin
      errors++; $display("FAIL peak cyc=%0d got %h want %h", cyc, peak_o, e_pk);
    end
    checks++;
    if (busy_o !== (q.size() != 0)) begin
      errors++; $display("FAIL busy cyc=%0d got %b want %b", cyc, busy_o, q.size() != 0);
    end
    eff = (win == 0) ? 1 : win;
    exp_vld = '0;
    if (clr) begin
      q.delete();
      for (int k = 0; k < N; k++) begin rm[k] = 0; cn[k] = 0; end
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e  = q.pop_front();
      mx = (e.mag > rm[e.ch]) ? e.mag : rm[e.ch];
      if (cn[e.ch] + 1 >= eff) begin
        pk[e.ch] = mx; exp_vld[e.ch] = 1'b1; rm[e.ch] = 0; cn[e.ch] = 0;
      end else begin
        rm[e.ch] = mx; cn[e.ch] = cn[e.ch] + 1;
      end
    end
    if (g >= 0) begin
      e.ch = g; e.mag = absmag(dv[g]); e.due = cyc + 2;
      q.push_back(e);
      m_ptr = (g + 1) % N;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; ch_val_i = '1; clr_i = 1'b0; win_len_i = W'(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (peak_o !== '0) begin errors++; $display("FAIL rst_peak got %h want 0", peak_o); end
    checks++;
    if (peak_vld_o !== '0) begin errors++; $display("FAIL rst_vld got %b want 0", peak_vld_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
    @(posedge clk); #1;
    ch_val_i = '0; rstn_i = 1'b1;
    model_reset();
    step('0, 1, 0);
    checks++;
    if (obs_rdy !== '0) begin errors++; $display("FAIL rst_idle_rdy got %b want 0", obs_rdy); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] e;
    for (int k = 0; k < N; k++) dv[k] = 10 * (k + 1);
    for (int i = 0; i < 12; i++) begin
      step('1, 1, 0);
      e = '0; e[i % N] = 1'b1;
      checks++;
      if (obs_rdy !== e) begin errors++; $display("FAIL rr_all i=%0d got %b want %b", i, obs_rdy, e); end
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b0100, 1, 0);
      checks++;
      if (obs_rdy !== 4'b0100) begin errors++; $display("FAIL rr_ch2 i=%0d got %b want 0100", i, obs_rdy); end
    end
    repeat (3) step('0, 1, 0);
  endtask

  task automatic test_saturation();
    int s[4];
    int want[4];
    s = '{-8192, 8191, -1, 0};
    want = '{8191, 8191, 1, 0};
    for (int j = 0; j < 7; j++) begin
      dv[1] = (j < 4) ? s[j] : 0;
      step((j < 4) ? 4'b0010 : 4'b0000, 1, 0);
      checks++;
      if (obs_vld[1] !== (j >= 3)) begin
        errors++; $display("FAIL sat_vld j=%0d got %b want %b", j, obs_vld[1], j >= 3);
      end
      if (j >= 3) begin
        checks++;
        if (obs_peak[1*M +: M] !== M'(want[j-3])) begin
          errors++; $display("FAIL sat_peak j=%0d got %0d want %0d", j, obs_peak[1*M +: M], want[j-3]);
        end
      end
    end
  endtask

  task automatic test_window();
    int s[8];
    int nv;
    s = '{100, -500, 20, 30, 1, 2, 3, 4};
    nv = 0;
    for (int j = 0; j < 11; j++) begin
      dv[0] = (j < 8) ? s[j] : 0;
      step((j < 8) ? 4'b0001 : 4'b0000, 4, 0);
      if (obs_vld[0]) nv++;
      if (j == 6 || j == 10) begin
        checks++;
        if (obs_vld[0] !== 1'b1 || obs_peak[0 +: M] !== M'((j == 6) ? 500 : 4)) begin
          errors++; $display("FAIL win_peak j=%0d got %b/%0d want 1/%0d", j, obs_vld[0], obs_peak[0 +: M], (j == 6) ? 500 : 4);
        end
      end
    end
    checks++;
    if (nv != 2) begin errors++; $display("FAIL win_count got %0d want 2", nv); end
  endtask

  task automatic test_win_zero();
    int nv;
    nv = 0;
    for (int j = 0; j < 8; j++) begin
      dv[2] = int'($urandom_range(0, 16383)) - 8192;
      step((j < 5) ? 4'b0100 : 4'b0000, 0, 0);
      if (obs_vld[2]) nv++;
    end
    checks++;
    if (nv != 5) begin errors++; $display("FAIL win0_count got %0d want 5", nv); end
  endtask

  task automatic test_clear();
    int s[7];
    logic [M-1:0] prev;
    int nv;
    s = '{100, -700, 300, 50, -20, 900, -950};
    prev = peak_o[3*M +: M];
    nv = 0;
    for (int j = 0; j < 11; j++) begin
      dv[3] = (j < 7) ? s[j] : 0;
      step((j < 7) ? 4'b1000 : 4'b0000, 8, j == 7);
      if (obs_vld[3]) nv++;
    end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL clr_strobe got %0d want 0", nv); end
    checks++;
    if (obs_peak[3*M +: M] !== prev) begin
      errors++; $display("FAIL clr_keep got %0d want %0d", obs_peak[3*M +: M], prev);
    end
    for (int j = 0; j < 11; j++) begin
      dv[3] = j + 1;
      step((j < 8) ? 4'b1000 : 4'b0000, 8, 0);
      checks++;
      if (obs_vld[3] !== (j == 10)) begin
        errors++; $display("FAIL clr_fresh j=%0d got %b want %b", j, obs_vld[3], j == 10);
      end
    end
    checks++;
    if (obs_peak[3*M +: M] !== M'(8)) begin
      errors++; $display("FAIL clr_newpeak got %0d want 8", obs_peak[3*M +: M]);
    end
  endtask

  task automatic test_random();
    int win;
    win = 3;
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) win = int'($urandom_range(0, 6));
      for (int k = 0; k < N; k++) begin
        dv[k] = int'($urandom_range(0, 16383)) - 8192;
        if ($urandom_range(0, 15) == 0) dv[k] = -8192;
      end
      step(N'($urandom), win, $urandom_range(0, 24) == 0);
    end
    repeat (3) step('0, win, 0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < N; k++) dv[k] = int'($urandom_range(0, 16383)) - 8192;
      step('1, 5, 0);
    end
    rstn_i = 1'b0; ch_val_i = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy_o); end
    rstn_i = 1'b1;
    model_reset();
    step(4'b1010, 5, 0);
    checks++;
    if (obs_rdy !== 4'b0010) begin errors++; $display("FAIL mid_rst_first got %b want 0010", obs_rdy); end
    repeat (4) step('0, 5, 0);
  endtask

  initial begin
    rstn_i = 1'b0; ch_val_i = '0; ch_dat_i = '0; win_len_i = '0; clr_i = 1'b0;
    cyc = 0;
    for (int k = 0; k < N; k++) dv[k] = 0;
    model_reset();
    test_reset();
    test_fairness();
    test_saturation();
    test_window();
    test_win_zero();
    test_clear();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lock_abs_peak_arb.md
# lock_abs_peak_arb

Shared-magnitude peak scheduler for the lock-in block. Up to N signal sources (error signal, demodulated quadratures, PID outputs) request a single saturating absolute-value stage through a round-robin arbiter. The block tracks the per-channel maximum magnitude over a programmable sample window and publishes each window's peak to the register bank with a one-cycle valid strobe. Its results drive the lock-detect and out-of-range logic.

## Interface
- R, 14: sample width (signed two's complement)
- N, 4: number of requesting channels (2..8)
- W, 20: width of window-length counter
- clk_i  in  1  system clock (125 MHz ADC clock)
- rstn_i  in  1  reset; one clock, reset is synchronous and active-low
- ch_val_i  in  N  per-channel sample valid
- ch_dat_i  in  N*R  packed signed samples, channel k at [k*R +: R]
- ch_rdy_o  out  N  one-hot grant; sample k accepted when ch_val_i[k] & ch_rdy_o[k]
- win_len_i  in  W  samples per window, per channel; 0 treated as 1
- clr_i  in  1  synchronous clear of running maxima and counters
- peak_o  out  N*(R-1)  packed last-window peak magnitude, channel k at [k*(R-1) +: R-1]
- peak_vld_o  out  N  one-cycle strobe, channel k's peak_o updated
- busy_o  out  1  high while any sample is in the pipeline

## Operation
- Arbiter: combinational one-hot grant from ch_val_i and a registered pointer. Search starts at pointer, ascending with wrap N-1→0. After a grant to k, the pointer becomes (k+1) mod N. With no valid input, there is no grant and the pointer holds. At most one accept per cycle. A channel holding ch_val_i waits at most N-1 cycles.
- Stage A register: accepted sample and channel index, with a valid bit.
- Stage B register: magnitude, R-1 bits unsigned. Non-negative x gives x[R-2:0]. Negative x gives -x. The most negative value, -2^(R-1) (-8192 for R=14), saturates to 2^(R-1)-1 (8191). No wrap to 0 is permitted.
- Update stage, per channel k, on stage-B valid:
  - run_max[k] becomes max(run_max[k], mag). cnt[k] increments.
  - If cnt[k]+1 ≥ eff_len, where eff_len = max(win_len_i,1):
    - peak_o[k] takes max(run_max[k], mag), including the current sample.
    - peak_vld_o[k] pulses.
    - run_max[k] and cnt[k] return to 0.
- win_len_i is sampled at each update. Lowering it below a channel's current count closes that window on the channel's next sample.
- clr_i has priority over everything:
  - Clears run_max, cnt and the stage A/B valid bits, so in-flight samples are dropped.
  - Accepts are still granted that cycle; the accepted sample enters stage A after the clear.
  - peak_o is retained.
- busy_o = stageA_valid | stageB_valid.

## Timing
- Reset values: ch_rdy_o combinational (all 0 while ch_val_i=0), peak_o 0, peak_vld_o 0, busy_o 0, pointer 0, run_max/cnt 0, stage valids 0.
- Accept at edge E0 → stage A after E0 → stage B after E1 → peak_o/peak_vld_o registered at E2, high for exactly the cycle after E2.
- Latency from accept cycle to peak_vld_o high: 3 cycles. Throughput: 1 sample/cycle aggregate.
- Multiple channels can finish windows on consecutive cycles. Strobes never overlap within one cycle, since there is one update per cycle.
- Reset mid-operation: all pipeline contents are lost; the first grant after rstn_i rises goes to the lowest valid channel.

## Test plan
- Reset: hold rstn_i=0 with all ch_val_i=1 → ch_rdy_o may be non-zero but nothing is accepted. peak_o=0, peak_vld_o=0, busy_o=0. After release, the first grant is ch0.
- Fairness: N=4, all ch_val_i held 1 for 12 cycles → grants cycle ch0,ch1,ch2,ch3 ×3. Then only ch2 valid → ch2 granted every cycle.
- Saturation: win_len_i=1, ch1 sends -8192, 8191, -1, 0 → peak_o[1] = 8191, 8191, 1, 0, with peak_vld_o[1] 3 cycles after each accept.
- Window: win_len_i=4, ch0 sends 100, -500, 20, 30 → one peak_vld_o[0] pulse with peak 500. The next window of 1,2,3,4 gives peak 4, proving the max was reset.
- win_len_i=0 behaves as 1: a strobe for every sample.
- Clear: with win_len_i=8 and ch3 midway (5 samples, max 700), pulse clr_i alongside two in-flight samples → no strobe from the in-flight samples. peak_o[3] keeps its previous value, and the next window needs 8 fresh samples.
